ip_tx_src_arb: RTL and testbench
================================

# ip_tx_src_arb

Round-robin arbiter that shares the single IP encapsulation TX path among `NUM_SRCS` transport-layer requesters (TCP, UDP, ICMP engines). Each requester presents a metadata/data stream pair. The arbiter locks a grant for one whole packet: one metadata handshake followed by data beats up to and including `last`. It then releases the grant and rotates priority. It sits directly upstream of the IP encap TX controller's metadata and data inputs.

## Interface
- `NUM_SRCS`, 2: number of requesters; must be ≥2.
- `META_W`, 96: metadata bus width (dst IP, length, protocol).
- `DATA_W`, 512: data bus width.
- `PAD_W`, 6: width of the padbytes field.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `src_arb_meta_val` in NUM_SRCS: per-source metadata valid.
- `src_arb_meta` in NUM_SRCS*META_W: per-source metadata; source i occupies bits [i*META_W +: META_W].
- `arb_src_meta_rdy` out NUM_SRCS: per-source metadata ready.
- `src_arb_data_val` in NUM_SRCS: per-source data valid.
- `src_arb_data` in NUM_SRCS*DATA_W: per-source data.
- `src_arb_data_last` in NUM_SRCS: per-source last beat.
- `src_arb_data_padbytes` in NUM_SRCS*PAD_W: per-source padbytes.
- `arb_src_data_rdy` out NUM_SRCS: per-source data ready.
- `arb_dst_meta_val` out 1: metadata valid toward IP encap.
- `arb_dst_meta` out META_W: muxed metadata.
- `dst_arb_meta_rdy` in 1: IP encap metadata ready.
- `arb_dst_data_val` out 1: data valid toward IP encap.
- `arb_dst_data` out DATA_W: muxed data.
- `arb_dst_data_last` out 1: muxed last.
- `arb_dst_data_padbytes` out PAD_W: muxed padbytes.
- `dst_arb_data_rdy` in 1: IP encap data ready.
- `arb_busy` out 1: high in any state other than IDLE.

## Operation
- Registers:
  - `state`: IDLE, META, DATA.
  - `grant_reg`: clog2(NUM_SRCS) bits.
  - `rr_ptr`: clog2(NUM_SRCS) bits.
- IDLE:
  - Search `src_arb_meta_val` starting at index `rr_ptr` and wrapping upward modulo NUM_SRCS.
  - On the first asserted source: latch its index into `grant_reg` and go to META.
  - If no source requests, stay in IDLE.
  - All outputs toward both sides are 0 in IDLE.
- META:
  - `arb_dst_meta_val` = `src_arb_meta_val[grant_reg]`.
  - `arb_dst_meta` = metadata of source `grant_reg`.
  - `arb_src_meta_rdy[grant_reg]` = `dst_arb_meta_rdy`; every other source's rdy is 0.
  - On a handshake (val & rdy), go to DATA.
- DATA:
  - `arb_dst_data_val`, `arb_dst_data`, `arb_dst_data_last`, `arb_dst_data_padbytes` are muxed from source `grant_reg`.
  - `arb_src_data_rdy[grant_reg]` = `dst_arb_data_rdy`; every other source's rdy is 0.
  - On a handshake with last=1: go to IDLE and set `rr_ptr` = `grant_reg`+1, wrapping NUM_SRCS-1 to 0.
- Metadata and data are never forwarded in the same cycle. Data presented by the granted source during META is held off (rdy=0).
- Data presented by non-granted sources is never accepted.
- Metadata and data output buses carry the muxed value whenever the corresponding val is high. Bus values while val is low are don't-care, but must not be X in simulation.
- Sources hold val/payload stable until their handshake completes. The arbiter does not check this.

## Timing
- Reset values:
  - `state`=IDLE, `rr_ptr`=0, `grant_reg`=0.
  - All `*_val`, `*_rdy` and `arb_busy` outputs are 0.
- Arbitration latency: request seen in IDLE in cycle N → `arb_dst_meta_val` high in cycle N+1.
- Metadata pass-through is combinational in META; zero added latency.
- Data pass-through is combinational in DATA; a full-throughput stream sustains 1 beat/cycle.
- Packet-to-packet gap: the last beat is accepted in cycle N; IDLE occupies N+1; the next metadata is presented in N+2.
- Single-beat packet (last=1 on the first beat): META → DATA → IDLE. One data handshake; `rr_ptr` updates as normal.
- Simultaneous requests from all sources are served in order `rr_ptr`, `rr_ptr`+1, …, wrapping. No source waits more than NUM_SRCS-1 packets.
- A lone requester is re-granted every packet; priority rotation does not starve it.
- Backpressure: `dst_*_rdy` low holds the state and the grant indefinitely.
- Reset asserted mid-packet: next cycle returns to the reset values. The partial packet is abandoned and the source must resend.

## Test plan
- Reset: hold `rst` 3 cycles with all sources requesting → all rdy/val outputs 0 during reset. First grant goes to source 0, and `arb_dst_meta_val` rises 1 cycle after reset deassertion.
- Round-robin, NUM_SRCS=2, both sources continuously sending 3-beat packets → grant order 0,1,0,1. Each packet is 1 meta + 3 data handshakes. `last` appears only on beat 3. Gap is exactly 1 IDLE cycle.
- Isolation: source 1 drives `data_val`=1 while source 0 owns the grant → `arb_src_data_rdy[1]`=0 throughout. Output data equals source 0's payload bit-exact.
- Backpressure: `dst_arb_data_rdy` toggles 1,0,0,1,… mid-packet → no beat is dropped or duplicated, and `arb_src_data_rdy[grant]` mirrors `dst_arb_data_rdy` each cycle.
- Single-beat packets: source 1 alone sends 4 one-beat packets (padbytes=5) → each is granted to source 1 with padbytes 5 passed through. Interval is 3 cycles per packet at full rdy.
- Reset mid-DATA, after beat 2 of 4 → outputs 0 next cycle, `rr_ptr`=0. The following request from source 1 is granted normally.

Source files
------------

// File: rtl/ip_tx_src_arb.sv
`default_nettype none
// ============================================================================
// Module      : ip_tx_src_arb
// Description : Round-robin arbiter sharing the IP encapsulation TX path among
//               NUM_SRCS transport-layer requesters. A grant is held for one
//               whole packet: one metadata handshake, then data beats up to
//               and including the beat that has last=1. After that packet the
//               grant is released and priority rotates to the next source.
// Revision    : 1.0 - initial release
// ============================================================================
module ip_tx_src_arb #(
  parameter int NUM_SRCS = 2,
  parameter int META_W   = 96,
  parameter int DATA_W   = 512,
  parameter int PAD_W    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  // Per-source metadata streams
  input  logic [NUM_SRCS-1:0]        src_arb_meta_val,
  input  logic [NUM_SRCS*META_W-1:0] src_arb_meta,
  output logic [NUM_SRCS-1:0]        arb_src_meta_rdy,
  // Per-source data streams
  input  logic [NUM_SRCS-1:0]        src_arb_data_val,
  input  logic [NUM_SRCS*DATA_W-1:0] src_arb_data,
  input  logic [NUM_SRCS-1:0]        src_arb_data_last,
  input  logic [NUM_SRCS*PAD_W-1:0]  src_arb_data_padbytes,
  output logic [NUM_SRCS-1:0]        arb_src_data_rdy,
  // Metadata toward the IP encap TX controller
  output logic                       arb_dst_meta_val,
  output logic [META_W-1:0]          arb_dst_meta,
  input  logic                       dst_arb_meta_rdy,
  // Data toward the IP encap TX controller
  output logic                       arb_dst_data_val,
  output logic [DATA_W-1:0]          arb_dst_data,
  output logic                       arb_dst_data_last,
  output logic [PAD_W-1:0]           arb_dst_data_padbytes,
  input  logic                       dst_arb_data_rdy,
  // Status
  output logic                       arb_busy
);

  // Source index width, and one extra bit so the wrap-around sum cannot overflow
  localparam int IDX_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SRCS - 1);
  localparam logic [SUM_W-1:0] NUM_SRCS_S = SUM_W'(NUM_SRCS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   grant_reg;
  logic [IDX_W-1:0]   grant_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_nxt;

  // Round-robin search results
  logic               req_found;
  logic [IDX_W-1:0]   req_idx;
  logic [SUM_W-1:0]   cand;

  // Per-source payloads split out of the flat buses
  logic [META_W-1:0]  meta_arr [NUM_SRCS];
  logic [DATA_W-1:0]  data_arr [NUM_SRCS];
  logic [PAD_W-1:0]   pad_arr  [NUM_SRCS];

  // Payload of the currently granted source
  logic               sel_meta_val;
  logic [META_W-1:0]  sel_meta;
  logic               sel_data_val;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_data_last;
  logic [PAD_W-1:0]   sel_pad;

  // Handshake qualifiers toward the destination
  logic               meta_fire;
  logic               data_last_fire;

  generate
    for (genvar i = 0; i < NUM_SRCS; i++) begin : g_unpack
      assign meta_arr[i] = src_arb_meta[i*META_W +: META_W];
      assign data_arr[i] = src_arb_data[i*DATA_W +: DATA_W];
      assign pad_arr[i]  = src_arb_data_padbytes[i*PAD_W +: PAD_W];
    end
  endgenerate

  // Find the first requesting source at or after rr_ptr, wrapping modulo NUM_SRCS
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      cand = {1'b0, rr_ptr} + SUM_W'(k);
      if (cand >= NUM_SRCS_S) begin
        cand = cand - NUM_SRCS_S;
      end
      if (!req_found && src_arb_meta_val[cand[IDX_W-1:0]]) begin
        req_found = 1'b1;
        req_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Mux the granted source's streams; used only in the matching state
  always_comb begin
    sel_meta_val  = src_arb_meta_val[grant_reg];
    sel_meta      = meta_arr[grant_reg];
    sel_data_val  = src_arb_data_val[grant_reg];
    sel_data      = data_arr[grant_reg];
    sel_data_last = src_arb_data_last[grant_reg];
    sel_pad       = pad_arr[grant_reg];
  end

  assign meta_fire      = sel_meta_val & dst_arb_meta_rdy;
  assign data_last_fire = sel_data_val & dst_arb_data_rdy & sel_data_last;

  // Priority moves to the source just after the one that finished its packet
  always_comb begin
    if (grant_reg == LAST_IDX) begin
      rr_nxt = '0;
    end else begin
      rr_nxt = grant_reg + 1'b1;
    end
  end

  // Next-state and output decode; everything is driven to 0 unless the state
  // routes one side of the granted source through
  always_comb begin
    state_nxt             = state;
    grant_nxt             = grant_reg;
    arb_src_meta_rdy      = '0;
    arb_src_data_rdy      = '0;
    arb_dst_meta_val      = 1'b0;
    arb_dst_meta          = '0;
    arb_dst_data_val      = 1'b0;
    arb_dst_data          = '0;
    arb_dst_data_last     = 1'b0;
    arb_dst_data_padbytes = '0;
    arb_busy              = 1'b1;

    case (state)
      IDLE: begin
        arb_busy = 1'b0;
        if (req_found) begin
          grant_nxt = req_idx;
          state_nxt = META;
        end
      end

      META: begin
        // Data from the granted source is held off until metadata is accepted
        arb_dst_meta_val            = sel_meta_val;
        arb_dst_meta                = sel_meta;
        arb_src_meta_rdy[grant_reg] = dst_arb_meta_rdy;
        if (meta_fire) begin
          state_nxt = DATA;
        end
      end

      DATA: begin
        arb_dst_data_val            = sel_data_val;
        arb_dst_data                = sel_data;
        arb_dst_data_last           = sel_data_last;
        arb_dst_data_padbytes       = sel_pad;
        arb_src_data_rdy[grant_reg] = dst_arb_data_rdy;
        if (data_last_fire) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_reg <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      grant_reg <= grant_nxt;
      if ((state == DATA) && data_last_fire) begin
        rr_ptr <= rr_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ip_tx_src_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip_tx_src_arb
// Description : Scoreboard bench for ip_tx_src_arb. Directed packets are
//               driven per source; expected handshakes are queued in the
//               hand-worked grant order and a negedge monitor checks them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_tx_src_arb;

  localparam int NS = 2;
  localparam int MW = 96;
  localparam int DW = 512;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Per-source stimulus, packed onto the DUT buses below
  logic          m_val  [NS] = '{default: 1'b0};
  logic [MW-1:0] m_dat  [NS] = '{default: '0};
  logic          d_val  [NS] = '{default: 1'b0};
  logic [DW-1:0] d_dat  [NS] = '{default: '0};
  logic          d_last [NS] = '{default: 1'b0};
  logic [PW-1:0] d_pad  [NS] = '{default: '0};

  wire  [NS-1:0]    src_arb_meta_val;
  wire  [NS*MW-1:0] src_arb_meta;
  wire  [NS-1:0]    src_arb_data_val;
  wire  [NS*DW-1:0] src_arb_data;
  wire  [NS-1:0]    src_arb_data_last;
  wire  [NS*PW-1:0] src_arb_data_padbytes;
  logic [NS-1:0]    arb_src_meta_rdy;
  logic [NS-1:0]    arb_src_data_rdy;
  logic             arb_dst_meta_val;
  logic [MW-1:0]    arb_dst_meta;
  logic             dst_arb_meta_rdy = 1'b1;
  logic             arb_dst_data_val;
  logic [DW-1:0]    arb_dst_data;
  logic             arb_dst_data_last;
  logic [PW-1:0]    arb_dst_data_padbytes;
  logic             dst_arb_data_rdy = 1'b1;
  logic             arb_busy;

  generate
    for (genvar i = 0; i < NS; i++) begin : g_pack
      assign src_arb_meta_val[i]                 = m_val[i];
      assign src_arb_meta[i*MW +: MW]            = m_dat[i];
      assign src_arb_data_val[i]                 = d_val[i];
      assign src_arb_data[i*DW +: DW]            = d_dat[i];
      assign src_arb_data_last[i]                = d_last[i];
      assign src_arb_data_padbytes[i*PW +: PW]   = d_pad[i];
    end
  endgenerate

  ip_tx_src_arb #(
    .NUM_SRCS(NS), .META_W(MW), .DATA_W(DW), .PAD_W(PW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .src_arb_meta_val      (src_arb_meta_val),
    .src_arb_meta          (src_arb_meta),
    .arb_src_meta_rdy      (arb_src_meta_rdy),
    .src_arb_data_val      (src_arb_data_val),
    .src_arb_data          (src_arb_data),
    .src_arb_data_last     (src_arb_data_last),
    .src_arb_data_padbytes (src_arb_data_padbytes),
    .arb_src_data_rdy      (arb_src_data_rdy),
    .arb_dst_meta_val      (arb_dst_meta_val),
    .arb_dst_meta          (arb_dst_meta),
    .dst_arb_meta_rdy      (dst_arb_meta_rdy),
    .arb_dst_data_val      (arb_dst_data_val),
    .arb_dst_data          (arb_dst_data),
    .arb_dst_data_last     (arb_dst_data_last),
    .arb_dst_data_padbytes (arb_dst_data_padbytes),
    .dst_arb_data_rdy      (dst_arb_data_rdy),
    .arb_busy              (arb_busy)
  );

  initial forever #5 clk = ~clk;

  // Bookkeeping
  int passed   = 0;
  int total    = 0;
  int cyc      = 0;
  int drv_done = 0;
  int data_hs  = 0;
  bit abort    = 1'b0;
  bit bp_en    = 1'b0;

  typedef struct {
    int            src;
    logic [MW-1:0] meta;
    int            gap;   // required cycles since previous last beat; 0 = unchecked
  } meta_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [PW-1:0] pad;
  } data_exp_t;

  meta_exp_t mq[$];
  data_exp_t dq[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Destination data ready: all-ones, or the 1,0,0,1 pattern when enabled
  initial begin
    int bp_i;
    bp_i = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        dst_arb_data_rdy = (bp_i == 0 || bp_i == 3);
        bp_i = (bp_i + 1) % 4;
      end else begin
        dst_arb_data_rdy = 1'b1;
        bp_i = 0;
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 20000 cycles, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] beat_val(input logic [7:0] tag, input int b);
    logic [31:0] w;
    w = {tag, 8'(b), 16'hC35A};
    return {16{w}};
  endfunction

  task automatic push_pkt(input int s, input logic [MW-1:0] meta, input int nb,
                          input logic [7:0] tag, input logic [PW-1:0] pad, input int gap);
    meta_exp_t me;
    data_exp_t de;
    me.src = s; me.meta = meta; me.gap = gap;
    mq.push_back(me);
    for (int b = 0; b < nb; b++) begin
      de.data = beat_val(tag, b);
      de.last = (b == nb - 1);
      de.pad  = (b == nb - 1) ? pad : '0;
      dq.push_back(de);
    end
  endtask

  // Wait (bounded) until source s sees its metadata or data ready
  task automatic wait_rdy(input int s, input bit data, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (abort) return;
      if (data ? arb_src_data_rdy[s] : arb_src_meta_rdy[s]) begin
        ok = 1'b1;
        return;
      end
    end
    total++;
    $display("FAIL wait_rdy_src%0d: got no handshake in 200 cycles, expected one", s);
  endtask

  // Source model: one packet, holding val/payload until each handshake
  task automatic send_pkt(input int s, input logic [MW-1:0] meta, input int nb,
                          input logic [7:0] tag, input logic [PW-1:0] pad, input bit early);
    bit ok;
    m_val[s] = 1'b1;
    m_dat[s] = meta;
    if (early) begin
      d_val[s]  = 1'b1;
      d_dat[s]  = beat_val(tag, 0);
      d_last[s] = (nb == 1);
      d_pad[s]  = (nb == 1) ? pad : '0;
    end
    wait_rdy(s, 1'b0, ok);
    if (!ok) begin
      m_val[s] = 1'b0; d_val[s] = 1'b0; d_last[s] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    m_val[s] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      d_val[s]  = 1'b1;
      d_dat[s]  = beat_val(tag, b);
      d_last[s] = (b == nb - 1);
      d_pad[s]  = (b == nb - 1) ? pad : '0;
      wait_rdy(s, 1'b1, ok);
      if (!ok) begin
        d_val[s] = 1'b0; d_last[s] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    d_val[s]  = 1'b0;
    d_last[s] = 1'b0;
    drv_done++;
  endtask

  task automatic wait_done(input int target);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (drv_done >= target) return;
    end
    total++;
    $display("FAIL wait_done: got %0d packets complete, expected %0d", drv_done, target);
  endtask

  // Monitor: per-cycle routing checks plus scoreboard comparison on handshakes
  initial begin
    bit            in_data;
    int            cur_src;
    int            last_cyc;
    int            es;
    logic [NS-1:0] oh;
    meta_exp_t     me;
    data_exp_t     de;
    in_data  = 1'b0;
    cur_src  = 0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        dq.delete();
        in_data = 1'b0;
      end else begin
        if (!arb_busy) begin
          check("idle_quiet", {arb_dst_meta_val, arb_dst_data_val, arb_src_meta_rdy, arb_src_data_rdy}, '0);
        end else if (!in_data) begin
          es = (mq.size() > 0) ? mq[0].src : 0;
          oh = '0;
          oh[es] = dst_arb_meta_rdy;
          check("meta_phase_meta_rdy", arb_src_meta_rdy, oh);
          check("meta_phase_data_held", {arb_dst_data_val, arb_src_data_rdy}, '0);
        end else begin
          oh = '0;
          oh[cur_src] = dst_arb_data_rdy;
          check("data_rdy_mirror", arb_src_data_rdy, oh);
          check("data_phase_meta_quiet", {arb_dst_meta_val, arb_src_meta_rdy}, '0);
          check("data_val_pass", arb_dst_data_val, d_val[cur_src]);
        end

        if (arb_dst_meta_val && dst_arb_meta_rdy) begin
          if (mq.size() == 0) begin
            total++;
            $display("FAIL meta_unexpected: got meta %0h, expected no metadata", arb_dst_meta);
          end else begin
            me = mq.pop_front();
            check("meta_value", arb_dst_meta, me.meta);
            if (me.gap > 0) check("meta_gap", cyc - last_cyc, me.gap);
            in_data = 1'b1;
            cur_src = me.src;
          end
        end

        if (arb_dst_data_val && dst_arb_data_rdy) begin
          data_hs++;
          if (dq.size() == 0) begin
            total++;
            $display("FAIL data_unexpected: got data %0h, expected no beat", arb_dst_data);
          end else begin
            de = dq.pop_front();
            check("data_value", arb_dst_data, de.data);
            check("data_last", arb_dst_data_last, de.last);
            check("data_pad", arb_dst_data_padbytes, de.pad);
          end
          if (arb_dst_data_last) begin
            in_data  = 1'b0;
            last_cyc = cyc;
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int target;

    // Reset with both sources requesting; then round-robin 0,1,0,1, 3-beat packets
    fork
      begin
        send_pkt(0, 96'hA0, 3, 8'h10, 6'd0, 1'b0);
        send_pkt(0, 96'hA2, 3, 8'h12, 6'd0, 1'b0);
      end
      begin
        send_pkt(1, 96'hB1, 3, 8'h11, 6'd0, 1'b0);
        send_pkt(1, 96'hB3, 3, 8'h13, 6'd0, 1'b0);
      end
    join_none
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", {arb_busy, arb_dst_meta_val, arb_dst_data_val, arb_src_meta_rdy, arb_src_data_rdy}, '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_pkt(0, 96'hA0, 3, 8'h10, 6'd0, 0);
    push_pkt(1, 96'hB1, 3, 8'h11, 6'd0, 2);
    push_pkt(0, 96'hA2, 3, 8'h12, 6'd0, 2);
    push_pkt(1, 96'hB3, 3, 8'h13, 6'd0, 2);
    @(negedge clk);
    check("post_reset_idle_meta_val", {arb_busy, arb_dst_meta_val}, '0);
    @(negedge clk);
    check("first_grant_meta_val", arb_dst_meta_val, 1'b1);
    check("first_grant_src0", arb_src_meta_rdy, 2'b01);
    wait_done(4);

    // Isolation: source 1 raises data early while source 0 owns the grant
    push_pkt(0, 96'hC0, 3, 8'h20, 6'd0, 0);
    push_pkt(1, 96'hC1, 3, 8'h21, 6'd3, 2);
    fork
      send_pkt(0, 96'hC0, 3, 8'h20, 6'd0, 1'b0);
      send_pkt(1, 96'hC1, 3, 8'h21, 6'd3, 1'b1);
    join_none
    wait_done(6);

    // Backpressure: 1,0,0,1 data ready pattern over a 5-beat packet
    bp_en = 1'b1;
    push_pkt(0, 96'hD0, 5, 8'h30, 6'd7, 0);
    fork
      send_pkt(0, 96'hD0, 5, 8'h30, 6'd7, 1'b0);
    join_none
    wait_done(7);
    bp_en = 1'b0;
    repeat (2) @(negedge clk);

    // Lone requester: four single-beat packets from source 1, padbytes 5
    push_pkt(1, 96'hE0, 1, 8'h40, 6'd5, 0);
    push_pkt(1, 96'hE1, 1, 8'h41, 6'd5, 2);
    push_pkt(1, 96'hE2, 1, 8'h42, 6'd5, 2);
    push_pkt(1, 96'hE3, 1, 8'h43, 6'd5, 2);
    fork
      begin
        send_pkt(1, 96'hE0, 1, 8'h40, 6'd5, 1'b0);
        send_pkt(1, 96'hE1, 1, 8'h41, 6'd5, 1'b0);
        send_pkt(1, 96'hE2, 1, 8'h42, 6'd5, 1'b0);
        send_pkt(1, 96'hE3, 1, 8'h43, 6'd5, 1'b0);
      end
    join_none
    wait_done(11);

    // Move priority to source 1, then reset in the middle of a 4-beat packet
    push_pkt(0, 96'hF0, 2, 8'h50, 6'd0, 0);
    fork
      send_pkt(0, 96'hF0, 2, 8'h50, 6'd0, 1'b0);
    join_none
    wait_done(12);
    push_pkt(0, 96'hF1, 4, 8'h51, 6'd0, 0);
    target = data_hs + 2;
    fork
      send_pkt(0, 96'hF1, 4, 8'h51, 6'd0, 1'b0);
    join_none
    begin : wait_two_beats
      for (int c = 0; c < 200; c++) begin
        @(posedge clk);
        if (data_hs >= target) disable wait_two_beats;
      end
      total++;
      $display("FAIL wait_two_beats: got %0d beats, expected %0d", data_hs, target);
    end
    #1;
    rst   = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("reset_mid_data_outputs", {arb_busy, arb_dst_meta_val, arb_dst_data_val, arb_src_meta_rdy, arb_src_data_rdy}, '0);
    // Both request; a reset pointer serves source 0 first, then source 1
    push_pkt(0, 96'h100, 2, 8'h60, 6'd0, 0);
    push_pkt(1, 96'h101, 2, 8'h61, 6'd2, 2);
    target = drv_done + 2;
    fork
      send_pkt(0, 96'h100, 2, 8'h60, 6'd0, 1'b0);
      send_pkt(1, 96'h101, 2, 8'h61, 6'd2, 1'b0);
    join_none
    wait_done(target);

    repeat (3) @(negedge clk);
    check("sb_meta_drained", mq.size(), 0);
    check("sb_data_drained", dq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
